// File: rtl/reorder_buffer.sv
// Reorder buffer: tags dispatched instructions, captures CDB results and
// retires completed entries strictly in program order, one per cycle.
module reorder_buffer #(
    parameter int  ROB_SIZE           = 16,
    parameter int  NUM_OF_FU          = 4,
    parameter int  ARCH_REG_NUM       = 32,
    parameter int  REG_VAL_WIDTH      = 32,
    localparam int ROB_SIZE_WIDTH     = $clog2(ROB_SIZE),
    localparam int ARCH_REG_NUM_WIDTH = $clog2(ARCH_REG_NUM)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    valid_inst_to_register,
    input  logic [ROB_SIZE_WIDTH-1:0]               inst_tag,
    input  logic [ARCH_REG_NUM_WIDTH-1:0]           dest_arch_register,
    input  logic                                    ctrl_reg_wb,
    input  logic                                    ctrl_is_branch,
    input  logic [1:0]                              ctrl_mem_op,
    input  logic [NUM_OF_FU-1:0]                    cdb_valid,
    input  logic [NUM_OF_FU*ROB_SIZE_WIDTH-1:0]     cdb_inst_tag,
    input  logic [NUM_OF_FU*ARCH_REG_NUM_WIDTH-1:0] cdb_register_addr,
    input  logic [NUM_OF_FU*REG_VAL_WIDTH-1:0]      cdb_register_val,
    output logic [ROB_SIZE_WIDTH-1:0]               next_tag,
    output logic                                    rob_full,
    output logic                                    rob_empty,
    output logic                                    commit_valid,
    output logic [ROB_SIZE_WIDTH-1:0]               commit_tag,
    output logic [ARCH_REG_NUM_WIDTH-1:0]           commit_arch_reg,
    output logic [REG_VAL_WIDTH-1:0]                commit_value,
    output logic                                    commit_reg_wb,
    output logic                                    commit_is_branch,
    output logic [1:0]                              commit_mem_op
);
    localparam int CW = ROB_SIZE_WIDTH + 1;
    localparam logic [CW-1:0]             FULL_COUNT = CW'(ROB_SIZE);
    localparam logic [CW-1:0]             CNT_ONE    = CW'(1);
    localparam logic [ROB_SIZE_WIDTH-1:0] TAG_ONE    = ROB_SIZE_WIDTH'(1);

    logic                          r_busy  [ROB_SIZE];
    logic                          r_ready [ROB_SIZE];
    logic [ARCH_REG_NUM_WIDTH-1:0] r_dest  [ROB_SIZE];
    logic [REG_VAL_WIDTH-1:0]      r_value [ROB_SIZE];
    logic                          r_wb    [ROB_SIZE];
    logic                          r_br    [ROB_SIZE];
    logic [1:0]                    r_mem   [ROB_SIZE];

    logic [ROB_SIZE_WIDTH-1:0]     r_head;
    logic [ROB_SIZE_WIDTH-1:0]     r_tail;
    logic [CW-1:0]                 r_count;

    logic                          r_commit_valid;
    logic [ROB_SIZE_WIDTH-1:0]     r_commit_tag;
    logic [ARCH_REG_NUM_WIDTH-1:0] r_commit_arch_reg;
    logic [REG_VAL_WIDTH-1:0]      r_commit_value;
    logic                          r_commit_reg_wb;
    logic                          r_commit_is_branch;
    logic [1:0]                    r_commit_mem_op;

    logic                          w_full;
    logic                          w_empty;
    logic                          w_dispatch;
    logic                          w_commit;
    logic                          w_cdb_hit [ROB_SIZE];
    logic [REG_VAL_WIDTH-1:0]      w_cdb_val [ROB_SIZE];
    logic                          w_lane_hit;
    logic                          w_unused_cdb_addr;

    // Destination register on the CDB is informational only.
    assign w_unused_cdb_addr = ^cdb_register_addr;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_dispatch = valid_inst_to_register && (inst_tag == r_tail) && !w_full;
    assign w_commit   = !w_empty && r_busy[r_head] && r_ready[r_head];

    // Per-entry CDB match; later lanes override earlier ones so the highest lane wins.
    always_comb begin
        w_lane_hit = 1'b0;
        for (int e = 0; e < ROB_SIZE; e++) begin
            w_cdb_hit[e] = 1'b0;
            w_cdb_val[e] = '0;
            for (int l = 0; l < NUM_OF_FU; l++) begin
                w_lane_hit   = cdb_valid[l] && r_busy[e] &&
                               (cdb_inst_tag[l*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH] == ROB_SIZE_WIDTH'(e));
                w_cdb_hit[e] = w_cdb_hit[e] | w_lane_hit;
                w_cdb_val[e] = w_lane_hit ? cdb_register_val[l*REG_VAL_WIDTH +: REG_VAL_WIDTH]
                                          : w_cdb_val[e];
            end
        end
    end

    // Entry storage: dispatch, then commit release, then CDB capture, in priority order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < ROB_SIZE; e++) begin
                r_busy[e]  <= 1'b0;
                r_ready[e] <= 1'b0;
                r_dest[e]  <= '0;
                r_value[e] <= '0;
                r_wb[e]    <= 1'b0;
                r_br[e]    <= 1'b0;
                r_mem[e]   <= 2'b00;
            end
        end else begin
            for (int e = 0; e < ROB_SIZE; e++) begin
                if (w_dispatch && (r_tail == ROB_SIZE_WIDTH'(e))) begin
                    r_busy[e]  <= 1'b1;
                    r_ready[e] <= 1'b0;
                    r_dest[e]  <= dest_arch_register;
                    r_value[e] <= '0;
                    r_wb[e]    <= ctrl_reg_wb;
                    r_br[e]    <= ctrl_is_branch;
                    r_mem[e]   <= ctrl_mem_op;
                end else if (w_commit && (r_head == ROB_SIZE_WIDTH'(e))) begin
                    r_busy[e]  <= 1'b0;
                    r_ready[e] <= 1'b0;
                end else if (w_cdb_hit[e]) begin
                    r_ready[e] <= 1'b1;
                    r_value[e] <= w_cdb_val[e];
                end
            end
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_dispatch) begin
                r_tail <= r_tail + TAG_ONE;
            end
            if (w_commit) begin
                r_head <= r_head + TAG_ONE;
            end
            case ({w_dispatch, w_commit})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered commit port; payload reads zero outside a retire pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_commit_valid     <= 1'b0;
            r_commit_tag       <= '0;
            r_commit_arch_reg  <= '0;
            r_commit_value     <= '0;
            r_commit_reg_wb    <= 1'b0;
            r_commit_is_branch <= 1'b0;
            r_commit_mem_op    <= 2'b00;
        end else if (w_commit) begin
            r_commit_valid     <= 1'b1;
            r_commit_tag       <= r_head;
            r_commit_arch_reg  <= r_dest[r_head];
            r_commit_value     <= r_value[r_head];
            r_commit_reg_wb    <= r_wb[r_head];
            r_commit_is_branch <= r_br[r_head];
            r_commit_mem_op    <= r_mem[r_head];
        end else begin
            r_commit_valid     <= 1'b0;
            r_commit_tag       <= '0;
            r_commit_arch_reg  <= '0;
            r_commit_value     <= '0;
            r_commit_reg_wb    <= 1'b0;
            r_commit_is_branch <= 1'b0;
            r_commit_mem_op    <= 2'b00;
        end
    end

    assign next_tag         = r_tail;
    assign rob_full         = w_full;
    assign rob_empty        = w_empty;
    assign commit_valid     = r_commit_valid;
    assign commit_tag       = r_commit_tag;
    assign commit_arch_reg  = r_commit_arch_reg;
    assign commit_value     = r_commit_value;
    assign commit_reg_wb    = r_commit_reg_wb;
    assign commit_is_branch = r_commit_is_branch;
    assign commit_mem_op    = r_commit_mem_op;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, self-checking bench for reorder_buffer: a vector table for in-order
// retire plus hand-written sequences for multi-lane, wrap, protocol and reset cases.
module tb_reorder_buffer;
    logic         clk;
    logic         reset;
    logic         valid_inst_to_register;
    logic [3:0]   inst_tag;
    logic [4:0]   dest_arch_register;
    logic         ctrl_reg_wb;
    logic         ctrl_is_branch;
    logic [1:0]   ctrl_mem_op;
    logic [3:0]   cdb_valid;
    logic [15:0]  cdb_inst_tag;
    logic [19:0]  cdb_register_addr;
    logic [127:0] cdb_register_val;
    logic [3:0]   next_tag;
    logic         rob_full;
    logic         rob_empty;
    logic         commit_valid;
    logic [3:0]   commit_tag;
    logic [4:0]   commit_arch_reg;
    logic [31:0]  commit_value;
    logic         commit_reg_wb;
    logic         commit_is_branch;
    logic [1:0]   commit_mem_op;

    int n_cmp  = 0;
    int n_fail = 0;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .valid_inst_to_register(valid_inst_to_register), .inst_tag(inst_tag),
        .dest_arch_register(dest_arch_register), .ctrl_reg_wb(ctrl_reg_wb),
        .ctrl_is_branch(ctrl_is_branch), .ctrl_mem_op(ctrl_mem_op),
        .cdb_valid(cdb_valid), .cdb_inst_tag(cdb_inst_tag),
        .cdb_register_addr(cdb_register_addr), .cdb_register_val(cdb_register_val),
        .next_tag(next_tag), .rob_full(rob_full), .rob_empty(rob_empty),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_arch_reg(commit_arch_reg), .commit_value(commit_value),
        .commit_reg_wb(commit_reg_wb), .commit_is_branch(commit_is_branch),
        .commit_mem_op(commit_mem_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         disp;
        logic [3:0]   dtag;
        logic [8:0]   dctl;
        logic [3:0]   cv;
        logic [15:0]  ctag;
        logic [127:0] cval;
        logic         e_cv;
        logic [3:0]   e_ctag;
        logic [8:0]   e_ctl;
        logic [31:0]  e_val;
        logic [3:0]   e_next;
        logic         e_empty;
        logic         e_full;
    } vec_t;

    vec_t tv [12];

    function automatic logic [8:0] ctl(input int d, input logic wb, input logic br, input int mem);
        return {5'(d), wb, br, 2'(mem)};
    endfunction

    function automatic vec_t mkv(input logic d, input logic [3:0] dt, input logic [8:0] dc,
                                 input int lane, input logic [3:0] ct, input logic [31:0] cval,
                                 input logic ecv, input logic [3:0] ect, input logic [8:0] ectl,
                                 input logic [31:0] eval, input logic [3:0] enext, input logic eempty);
        vec_t v;
        v = '0;
        v.disp = d; v.dtag = dt; v.dctl = dc;
        if (lane >= 0) begin
            v.cv[lane]            = 1'b1;
            v.ctag[lane*4 +: 4]   = ct;
            v.cval[lane*32 +: 32] = cval;
        end
        v.e_cv = ecv; v.e_ctag = ect; v.e_ctl = ectl; v.e_val = eval;
        v.e_next = enext; v.e_empty = eempty; v.e_full = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        valid_inst_to_register = 1'b0;
        inst_tag = 4'd0;
        {dest_arch_register, ctrl_reg_wb, ctrl_is_branch, ctrl_mem_op} = 9'd0;
        cdb_valid = 4'd0;
        cdb_inst_tag = 16'd0;
        cdb_register_addr = 20'd0;
        cdb_register_val = 128'd0;
    endtask

    task automatic disp(input logic [3:0] t, input logic [8:0] c);
        valid_inst_to_register = 1'b1;
        inst_tag = t;
        {dest_arch_register, ctrl_reg_wb, ctrl_is_branch, ctrl_mem_op} = c;
    endtask

    task automatic cdb(input int l, input logic [3:0] t, input logic [31:0] v);
        cdb_valid[l]               = 1'b1;
        cdb_inst_tag[l*4 +: 4]     = t;
        cdb_register_val[l*32 +: 32] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b0;
        #1;
        chk({nm, ".commit_valid"}, 32'(commit_valid), 32'd0);
        chk({nm, ".commit_tag"},   32'(commit_tag),   32'd0);
        chk({nm, ".commit_value"}, commit_value,      32'd0);
        chk({nm, ".commit_ctl"},   32'({commit_arch_reg, commit_reg_wb, commit_is_branch, commit_mem_op}), 32'd0);
        chk({nm, ".next_tag"},     32'(next_tag),     32'd0);
        chk({nm, ".empty"},        32'(rob_empty),    32'd1);
        chk({nm, ".full"},         32'(rob_full),     32'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    logic [3:0]  q_tag [$];
    logic [31:0] q_val [$];
    logic [4:0]  last_dest;

    initial begin
        reset = 1'b1;
        idle();
        #1;
        do_reset("por");

        // In-order retire: completions arrive out of order on various lanes.
        tv[0]  = mkv(1, 0, ctl(5,1,0,0), -1, 0, 0,            0, 0, 0, 0, 1, 0);
        tv[1]  = mkv(1, 1, ctl(6,1,0,1), -1, 0, 0,            0, 0, 0, 0, 2, 0);
        tv[2]  = mkv(1, 2, ctl(7,0,1,0), -1, 0, 0,            0, 0, 0, 0, 3, 0);
        tv[3]  = mkv(1, 3, ctl(8,1,0,2), -1, 0, 0,            0, 0, 0, 0, 4, 0);
        tv[4]  = mkv(0, 0, 0, 1, 2, 32'hAAAA_0002,            0, 0, 0, 0, 4, 0);
        tv[5]  = mkv(0, 0, 0, 0, 0, 32'h1111_0000,            0, 0, 0, 0, 4, 0);
        tv[6]  = mkv(0, 0, 0, -1, 0, 0, 1, 0, ctl(5,1,0,0), 32'h1111_0000, 4, 0);
        tv[7]  = mkv(0, 0, 0, 3, 1, 32'h3333_0001,            0, 0, 0, 0, 4, 0);
        tv[8]  = mkv(0, 0, 0, 3, 3, 32'h4444_0003, 1, 1, ctl(6,1,0,1), 32'h3333_0001, 4, 0);
        tv[9]  = mkv(0, 0, 0, -1, 0, 0, 1, 2, ctl(7,0,1,0), 32'hAAAA_0002, 4, 0);
        tv[10] = mkv(0, 0, 0, -1, 0, 0, 1, 3, ctl(8,1,0,2), 32'h4444_0003, 4, 1);
        tv[11] = mkv(0, 0, 0, -1, 0, 0,                       0, 0, 0, 0, 4, 1);

        for (int i = 0; i < 12; i++) begin
            idle();
            valid_inst_to_register = tv[i].disp;
            inst_tag = tv[i].dtag;
            {dest_arch_register, ctrl_reg_wb, ctrl_is_branch, ctrl_mem_op} = tv[i].dctl;
            cdb_valid = tv[i].cv;
            cdb_inst_tag = tv[i].ctag;
            cdb_register_val = tv[i].cval;
            tick();
            chk($sformatf("v%0d.commit_valid", i), 32'(commit_valid), 32'(tv[i].e_cv));
            if (tv[i].e_cv) begin
                chk($sformatf("v%0d.commit_tag", i), 32'(commit_tag), 32'(tv[i].e_ctag));
                chk($sformatf("v%0d.commit_value", i), commit_value, tv[i].e_val);
                chk($sformatf("v%0d.commit_ctl", i),
                    32'({commit_arch_reg, commit_reg_wb, commit_is_branch, commit_mem_op}), 32'(tv[i].e_ctl));
            end
            chk($sformatf("v%0d.next_tag", i), 32'(next_tag), 32'(tv[i].e_next));
            chk($sformatf("v%0d.empty", i), 32'(rob_empty), 32'(tv[i].e_empty));
            chk($sformatf("v%0d.full", i), 32'(rob_full), 32'(tv[i].e_full));
        end

        // Multi-lane: all four lanes complete in one cycle, four back-to-back retires.
        do_reset("rst_ml");
        for (int i = 0; i < 4; i++) begin
            idle();
            disp(4'(i), ctl(i + 1, 1, 0, 0));
            tick();
        end
        idle();
        for (int l = 0; l < 4; l++) cdb(l, 4'(3 - l), 32'hC0DE_0000 + 32'(l));
        tick();
        chk("ml.no_bypass", 32'(commit_valid), 32'd0);
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("ml%0d.commit_valid", k), 32'(commit_valid), 32'd1);
            chk($sformatf("ml%0d.commit_tag", k), 32'(commit_tag), 32'(k));
            chk($sformatf("ml%0d.commit_value", k), commit_value, 32'hC0DE_0000 + 32'(3 - k));
        end
        chk("ml.empty", 32'(rob_empty), 32'd1);

        // Full and wrap.
        do_reset("rst_fw");
        for (int i = 0; i < 16; i++) begin
            idle();
            disp(4'(i), ctl(i, 1, 0, 0));
            tick();
        end
        chk("fw.full", 32'(rob_full), 32'd1);
        chk("fw.next_tag", 32'(next_tag), 32'd0);
        idle();
        disp(4'd0, ctl(31, 1, 0, 0));
        tick();
        chk("fw.17th_full", 32'(rob_full), 32'd1);
        chk("fw.17th_next_tag", 32'(next_tag), 32'd0);
        idle();
        cdb(0, 4'd0, 32'h0000_F000);
        tick();
        // Dispatch while full on the commit edge must be refused.
        idle();
        disp(4'd0, ctl(31, 1, 0, 0));
        tick();
        chk("fw.c0_valid", 32'(commit_valid), 32'd1);
        chk("fw.c0_tag", 32'(commit_tag), 32'd0);
        chk("fw.c0_value", commit_value, 32'h0000_F000);
        chk("fw.c0_full", 32'(rob_full), 32'd0);
        chk("fw.c0_next_tag", 32'(next_tag), 32'd0);
        idle();
        disp(4'd0, ctl(30, 1, 0, 0));
        tick();
        chk("fw.redisp_next_tag", 32'(next_tag), 32'd1);
        chk("fw.redisp_full", 32'(rob_full), 32'd1);
        q_tag.delete();
        q_val.delete();
        last_dest = 5'd0;
        for (int s = 0; s < 30; s++) begin
            idle();
            if (s < 3) begin
                for (int l = 0; l < 4; l++) cdb(l, 4'(s*4 + l + 1), 32'h1000 + 32'(s*4 + l + 1));
            end else if (s == 3) begin
                for (int l = 0; l < 3; l++) cdb(l, 4'(13 + l), 32'h1000 + 32'(13 + l));
                cdb(3, 4'd0, 32'h0000_BEEF);
            end
            tick();
            if (commit_valid) begin
                q_tag.push_back(commit_tag);
                q_val.push_back(commit_value);
                last_dest = commit_arch_reg;
            end
        end
        chk("fw.commit_count", 32'(q_tag.size()), 32'd16);
        for (int j = 0; j < q_tag.size() && j < 16; j++) begin
            chk($sformatf("fw.order%0d_tag", j), 32'(q_tag[j]), (j < 15) ? 32'(j + 1) : 32'd0);
            chk($sformatf("fw.order%0d_val", j), q_val[j], (j < 15) ? 32'h1000 + 32'(j + 1) : 32'h0000_BEEF);
        end
        chk("fw.new0_dest", 32'(last_dest), 32'd30);
        chk("fw.empty", 32'(rob_empty), 32'd1);

        // Protocol errors and lane priority.
        do_reset("rst_pe");
        idle();
        disp(4'd3, ctl(9, 1, 0, 0));
        tick();
        chk("pe.badtag_next", 32'(next_tag), 32'd0);
        chk("pe.badtag_empty", 32'(rob_empty), 32'd1);
        idle();
        cdb(0, 4'd5, 32'h5555_5555);
        tick();
        idle();
        tick();
        chk("pe.nonbusy_commit", 32'(commit_valid), 32'd0);
        idle();
        disp(4'd0, ctl(9, 1, 0, 0));
        cdb(0, 4'd0, 32'hDEAD_0000);
        tick();
        chk("pe.disp_next", 32'(next_tag), 32'd1);
        idle();
        tick();
        chk("pe.disp_wins_a", 32'(commit_valid), 32'd0);
        tick();
        chk("pe.disp_wins_b", 32'(commit_valid), 32'd0);
        cdb(0, 4'd0, 32'h0000_0001);
        cdb(2, 4'd0, 32'h0000_2222);
        tick();
        idle();
        tick();
        chk("pe.lane_pri_valid", 32'(commit_valid), 32'd1);
        chk("pe.lane_pri_value", commit_value, 32'h0000_2222);

        // Reset mid-operation while a commit pulse is on the port.
        do_reset("rst_mid_pre");
        for (int i = 0; i < 3; i++) begin
            idle();
            disp(4'(i), ctl(i + 20, 1, 0, 0));
            tick();
        end
        idle();
        cdb(1, 4'd1, 32'h0101_0101);
        cdb(0, 4'd0, 32'h0000_0A0A);
        tick();
        idle();
        tick();
        chk("mid.pre_commit_valid", 32'(commit_valid), 32'd1);
        do_reset("mid");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid.post%0d_commit", k), 32'(commit_valid), 32'd0);
            chk($sformatf("mid.post%0d_empty", k), 32'(rob_empty), 32'd1);
            chk($sformatf("mid.post%0d_next", k), 32'(next_tag), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
